// File: rtl/sd_stream_loader_pkg.sv
// Shared definitions for the SD stream loader: FSM state encoding and error codes.
package sd_stream_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAGIC  = 3'd1,
    S_LEN_LO = 3'd2,
    S_LEN_HI = 3'd3,
    S_DATA   = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_MAGIC = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_OVF   = 2'd3;

endpackage

// File: rtl/sd_stream_loader_if.sv
// Byte stream from the SD reader plus the BRAM write port, bundled for the loader.
interface sd_stream_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              sd_rd_en;
  logic              sd_outen;
  logic [7:0]        sd_outbyte;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output sd_rd_en, wr_valid, wr_addr, wr_data,
    input  sd_outen, sd_outbyte, wr_ready
  );

  modport slave (
    input  sd_rd_en, wr_valid, wr_addr, wr_data,
    output sd_outen, sd_outbyte, wr_ready
  );
endinterface

// File: rtl/sd_stream_loader_word_fifo.sv
// Synchronous first-word-fall-through FIFO; push into a full FIFO is taken only with a pop.
module sd_word_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero when empty so the write data bus is quiet between words.
  assign head    = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/sd_stream_loader.sv
// Parses a framed SD file (magic, 16-bit LE word count, payload) and writes the packed
// payload words to sequential BRAM addresses through a small FWFT word FIFO.
module sd_stream_loader
  import sd_stream_loader_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter int         ADDR_W     = 12,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] MAGIC      = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  sd_stream_loader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_written
);
  localparam int          WB        = DATA_W / 8;
  localparam int          LANE_W    = (WB > 1) ? $clog2(WB) : 1;
  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [16:0]       len_q, len_d;
  logic [16:0]       pushed_q, pushed_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] pack_q, pack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, rden_q, rden_d;
  logic [1:0]        code_q, code_d;
  logic [15:0]       n_word;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  sd_word_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (pack_d),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fifo_pop      = !fifo_empty && bus.wr_ready;
  assign bus.wr_valid  = !fifo_empty;
  assign bus.wr_data   = fifo_head;
  assign bus.wr_addr   = addr_q;
  assign bus.sd_rd_en  = rden_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = code_q;
  assign words_written = wcnt_q;
  assign n_word        = {bus.sd_outbyte, len_lo_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    pushed_d   = pushed_q;
    lane_d     = lane_q;
    pack_d     = pack_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    rden_d     = rden_q;
    code_d     = code_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;

    if (fifo_pop) begin
      addr_d = addr_q + ADDR_W'(1);
      wcnt_d = wcnt_q + (ADDR_W+1)'(1);
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_MAGIC;
          busy_d     = 1'b1;
          rden_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          code_d     = ERR_NONE;
          pushed_d   = '0;
          lane_d     = '0;
          addr_d     = '0;
          wcnt_d     = '0;
          fifo_flush = 1'b1;
        end
      end
      S_MAGIC: begin
        if (bus.sd_outen) begin
          if (bus.sd_outbyte != MAGIC) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            code_d     = ERR_MAGIC;
            busy_d     = 1'b0;
            rden_d     = 1'b0;
            fifo_flush = 1'b1;
          end else begin
            state_d = S_LEN_LO;
          end
        end
      end
      S_LEN_LO: begin
        if (bus.sd_outen) begin
          len_lo_d = bus.sd_outbyte;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (bus.sd_outen) begin
          if (n_word == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            rden_d  = 1'b0;
          end else if (32'(n_word) > MAX_WORDS) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            code_d     = ERR_LEN;
            busy_d     = 1'b0;
            rden_d     = 1'b0;
            fifo_flush = 1'b1;
          end else begin
            len_d   = {1'b0, n_word};
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bus.sd_outen) begin
          pack_d[8*int'(lane_q) +: 8] = bus.sd_outbyte;
          if (lane_q == LANE_W'(WB-1)) begin
            lane_d = '0;
            // The reader cannot be stalled, so a word with nowhere to go aborts the load.
            if (fifo_full && !fifo_pop) begin
              state_d    = S_ERR;
              err_d      = 1'b1;
              code_d     = ERR_OVF;
              busy_d     = 1'b0;
              rden_d     = 1'b0;
              fifo_flush = 1'b1;
            end else begin
              fifo_push = 1'b1;
              pushed_d  = pushed_q + 17'd1;
              if (pushed_d == len_q) begin
                state_d = S_DRAIN;
                rden_d  = 1'b0;
              end
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pushed_q <= '0;
      lane_q   <= '0;
      addr_q   <= '0;
      wcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rden_q   <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      pushed_q <= pushed_d;
      lane_q   <= lane_d;
      addr_q   <= addr_d;
      wcnt_q   <= wcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rden_q   <= rden_d;
      code_q   <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    len_lo_q <= len_lo_d;
    len_q    <= len_d;
    pack_q   <= pack_d;
  end

endmodule

// File: tb/tb_sd_stream_loader.sv
// Directed bench for sd_stream_loader: framed-file vector table plus reset/restart sequences.
module tb_sd_stream_loader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_written;

  sd_stream_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sd_stream_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .MAGIC(8'hA5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_code      (err_code),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  // mode: 0 ready always 1, 1 ready toggling, 2 ready low for 40 cycles, 3 ready held low
  typedef struct {
    logic [7:0] magic;
    int         n;
    int         nbytes;
    int         mode;
    bit         e_done;
    bit         e_err;
    int         e_code;
    int         e_words;
  } vec_t;

  vec_t              vt [8];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                cyc   = 0;
  int                mode  = 0;
  bit                any_valid;
  logic [ADDR_W-1:0] cap_addr [$];
  logic [DATA_W-1:0] cap_data [$];

  // Inputs only move at posedge+1, so the negedge view equals what the next edge sees.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_valid) any_valid = 1'b1;
      if (bus.wr_valid && bus.wr_ready) begin
        cap_addr.push_back(bus.wr_addr);
        cap_data.push_back(bus.wr_data);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0:       bus.wr_ready = 1'b1;
      1:       bus.wr_ready = ~bus.wr_ready;
      2:       bus.wr_ready = (cyc >= 40);
      default: bus.wr_ready = 1'b0;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.sd_outen   = 1'b1;
    bus.sd_outbyte = b;
    tick();
    bus.sd_outen   = 1'b0;
  endtask

  function automatic logic [31:0] exp_word(input int w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = 8'(4*w + b);
    return r;
  endfunction

  task automatic begin_load(input int m);
    cap_addr.delete();
    cap_data.delete();
    any_valid     = 1'b0;
    mode          = m;
    cyc           = 0;
    bus.wr_ready  = (m == 0 || m == 1);
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy; i++) tick();
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
    tick();
  endtask

  task automatic check_writes(input string tag, input int nw);
    chk({tag, " n_writes"}, 32'(cap_addr.size()), 32'(nw));
    for (int w = 0; w < nw && w < cap_addr.size(); w++) begin
      chk($sformatf("%s addr%0d", tag, w), 32'(cap_addr[w]), 32'(w));
      chk($sformatf("%s data%0d", tag, w), cap_data[w], exp_word(w));
    end
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    begin_load(v.mode);
    chk({tag, " busy_start"}, 32'(busy), 32'd1);
    chk({tag, " rd_en_start"}, 32'(bus.sd_rd_en), 32'd1);
    send_byte(v.magic);
    if (v.magic != 8'hA5) begin
      chk({tag, " err_after_magic"}, 32'(err), 32'd1);
      chk({tag, " rd_en_after_magic"}, 32'(bus.sd_rd_en), 32'd0);
    end
    send_byte(8'(v.n));
    send_byte(8'(v.n >> 8));
    for (int k = 0; k < v.nbytes; k++) send_byte(8'(k));
    wait_idle(tag);
    chk({tag, " done"}, 32'(done), 32'(v.e_done));
    chk({tag, " err"}, 32'(err), 32'(v.e_err));
    chk({tag, " err_code"}, 32'(err_code), 32'(v.e_code));
    chk({tag, " words_written"}, 32'(words_written), 32'(v.e_words));
    chk({tag, " rd_en_end"}, 32'(bus.sd_rd_en), 32'd0);
    check_writes(tag, v.e_words);
    if (v.e_code == 1 || v.e_code == 2) chk({tag, " wr_valid_seen"}, 32'(any_valid), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " err_code"}, 32'(err_code), 32'd0);
    chk({tag, " words_written"}, 32'(words_written), 32'd0);
    chk({tag, " sd_rd_en"}, 32'(bus.sd_rd_en), 32'd0);
    chk({tag, " wr_valid"}, 32'(bus.wr_valid), 32'd0);
    chk({tag, " wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, " wr_data"}, bus.wr_data, 32'd0);
  endtask

  initial begin
    //          magic  n     nbytes mode done err code words
    vt[0] = '{8'hA5, 3,    12,    0,   1'b1, 1'b0, 0, 3};
    vt[1] = '{8'h5A, 3,    12,    0,   1'b0, 1'b1, 1, 0};
    vt[2] = '{8'hA5, 4097, 8,     0,   1'b0, 1'b1, 2, 0};
    vt[3] = '{8'hA5, 0,    4,     0,   1'b1, 1'b0, 0, 0};
    vt[4] = '{8'hA5, 8,    32,    2,   1'b0, 1'b1, 3, 0};
    vt[5] = '{8'hA5, 8,    32,    1,   1'b1, 1'b0, 0, 8};
    vt[6] = '{8'hA5, 3,    17,    0,   1'b1, 1'b0, 0, 3};
    vt[7] = '{8'hA5, 1,    4,     1,   1'b1, 1'b0, 0, 1};

    rst            = 1'b1;
    start          = 1'b0;
    bus.sd_outen   = 1'b0;
    bus.sd_outbyte = 8'h00;
    bus.wr_ready   = 1'b0;
    mode           = 3;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vector(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of DATA with words parked in the FIFO.
    begin_load(3);
    send_byte(8'hA5);
    send_byte(8'h08);
    send_byte(8'h00);
    for (int k = 0; k < 10; k++) send_byte(8'(k));
    chk("midrst wr_valid_before", 32'(bus.wr_valid), 32'd1);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    tick();
    run_vector(vt[0], "reload");

    // A start pulse during an active load must not restart it.
    begin_load(0);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h00);
    for (int k = 0; k < 12; k++) begin
      start = (k == 5);
      send_byte(8'(k));
      start = 1'b0;
      if (k == 5) chk("restart busy_held", 32'(busy), 32'd1);
    end
    wait_idle("restart");
    chk("restart done", 32'(done), 32'd1);
    chk("restart err", 32'(err), 32'd0);
    chk("restart words_written", 32'(words_written), 32'd3);
    check_writes("restart", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
